// File: rtl/stream_demux_buf.sv
// 1-to-NCH valid/ready demultiplexer with a one-entry register per output channel.
// Optional per-channel delivery counters are built when DEMUX_STATS_EN is defined.
module stream_demux_buf #(
  parameter int DW  = 3,
  parameter int NCH = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic              sel_err,
  input  logic [SW-1:0]     stat_sel,
  output logic [15:0]       stat_cnt
);

  logic [NCH-1:0]         full_r;
  logic [NCH-1:0][DW-1:0] data_r;
  logic                   sel_err_r;

  logic [NCH-1:0] sel_hit_s;
  logic [NCH-1:0] pop_s;
  logic [NCH-1:0] load_s;
  logic           sel_bad_s;
  logic           accept_s;

  // Decode destination; an out-of-range select hits no channel and is never blocked.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sel_hit_s[k] = (in_sel == SW'(k));
    end
    sel_bad_s = ~|sel_hit_s;
    pop_s     = full_r & out_ready;
    in_ready  = en & ~|(sel_hit_s & full_r & ~out_ready);
    accept_s  = in_valid & in_ready;
    load_s    = accept_s ? sel_hit_s : {NCH{1'b0}};
  end

  // Channel registers: a load wins over a same-cycle pop so full stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r    <= {NCH{1'b0}};
      data_r    <= {(NCH*DW){1'b0}};
      sel_err_r <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load_s[k]) begin
          full_r[k] <= 1'b1;
          data_r[k] <= in_data;
        end else if (pop_s[k]) begin
          full_r[k] <= 1'b0;
        end else begin
          full_r[k] <= full_r[k];
        end
      end
      sel_err_r <= accept_s & sel_bad_s;
    end
  end

  assign out_valid = full_r;
  assign out_data  = data_r;
  assign sel_err   = sel_err_r;

`ifdef DEMUX_STATS_EN
  logic [NCH-1:0][15:0] cnt_r;

  // Saturating delivered-word counters, one per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {(NCH*16){1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (pop_s[k] && (cnt_r[k] != 16'hFFFF)) begin
          cnt_r[k] <= cnt_r[k] + 16'd1;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Readout mux; an out-of-range index reads zero.
  always_comb begin
    stat_cnt = 16'h0000;
    for (int k = 0; k < NCH; k++) begin
      stat_cnt = (stat_sel == SW'(k)) ? cnt_r[k] : stat_cnt;
    end
  end
`else
  logic unused_stat_s;
  assign unused_stat_s = ^stat_sel;
  assign stat_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_stream_demux_buf.sv
// Directed + random bench for stream_demux_buf with a per-channel queue scoreboard.
module tb_stream_demux_buf;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, sel_err;
  logic [2:0]  in_data, in_sel, stat_sel;
  logic [7:0]  out_valid, out_ready;
  logic [23:0] out_data;
  logic [15:0] stat_cnt;

  logic        en6, iv6, ir6, se6;
  logic [2:0]  id6, is6, ss6;
  logic [5:0]  ov6, or6;
  logic [17:0] od6;
  logic [15:0] sc6;

  int npass = 0, nfail = 0, ntotal = 0;

  always #5 clk = ~clk;

  stream_demux_buf #(.DW(3), .NCH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sel_err(sel_err), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  stream_demux_buf #(.DW(3), .NCH(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en6), .in_valid(iv6), .in_ready(ir6),
    .in_data(id6), .in_sel(is6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .sel_err(se6), .stat_sel(ss6), .stat_cnt(sc6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected words per channel, sampled mid-cycle when inputs are stable.
  logic [2:0] q [8][$];
  logic       exp_se = 1'b0;
  logic       ir_exp;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) q[k].delete();
      exp_se = 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("sb_valid%0d", k), out_valid[k], q[k].size() != 0);
        if (q[k].size() != 0) chk($sformatf("sb_data%0d", k), out_data[k*3 +: 3], q[k][0]);
      end
      chk("sb_sel_err", sel_err, exp_se);
      ir_exp = en & ~((q[in_sel].size() != 0) & ~out_ready[in_sel]);
      chk("sb_in_ready", in_ready, ir_exp);
      for (int k = 0; k < 8; k++)
        if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      if (in_valid && ir_exp) q[in_sel].push_back(in_data);
      exp_se = 1'b0;
    end
  end

  initial begin
    logic [23:0] all5;
    all5 = {8{3'b101}};
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 3'b111; in_sel = 3'd0;
    out_ready = 8'hFF; stat_sel = 3'd0;
    en6 = 1'b1; iv6 = 1'b0; id6 = 3'd0; is6 = 3'd0; or6 = 6'h3F; ss6 = 3'd0;

    // Reset with in_valid held high
    tick(); tick();
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_sel_err", sel_err, 1'b0);
    chk("rst_stat_cnt", stat_cnt, 16'h0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 8'h00);

    // Routing to every channel
    for (int s = 0; s < 8; s++) begin
      in_valid = 1'b1; in_data = 3'b101; in_sel = 3'(s);
      #1 chk("route_in_ready", in_ready, 1'b1);
      tick();
      chk($sformatf("route_valid%0d", s), out_valid, 8'h01 << s);
      chk($sformatf("route_data%0d", s), out_data[s*3 +: 3], 3'b101);
    end
    in_valid = 1'b0;
    tick();
    chk("route_drained", out_valid, 8'h00);
    chk("route_regs_hold", out_data, all5);

    // Stall on channel 2
    out_ready = 8'hFB; in_valid = 1'b1; in_data = 3'b011; in_sel = 3'd2;
    #1 chk("stall_first_ready", in_ready, 1'b1);
    tick();
    chk("stall_valid", out_valid, 8'h04);
    chk("stall_data", out_data[8:6], 3'b011);
    in_data = 3'b110;
    #1 chk("stall_blocked", in_ready, 1'b0);
    tick();
    chk("stall_held_valid", out_valid, 8'h04);
    chk("stall_held_data", out_data[8:6], 3'b011);

    // Independence: channel 5 accepts while channel 2 is stalled
    in_sel = 3'd5; in_data = 3'b010;
    #1 chk("indep_ready", in_ready, 1'b1);
    tick();
    chk("indep_valid", out_valid, 8'h24);
    chk("indep_ch5", out_data[17:15], 3'b010);
    chk("indep_ch2", out_data[8:6], 3'b011);

    // Release: pop and load on channel 2 in the same cycle
    in_sel = 3'd2; in_data = 3'b110; out_ready = 8'hFF;
    #1 chk("release_ready", in_ready, 1'b1);
    tick();
    chk("release_valid", out_valid, 8'h04);
    chk("release_data", out_data[8:6], 3'b110);
    in_valid = 1'b0;
    tick();
    chk("release_drained", out_valid, 8'h00);

    // en=0 blocks input
    en = 1'b0; in_valid = 1'b1; in_sel = 3'd3;
    #1 chk("en0_ready", in_ready, 1'b0);
    tick();
    chk("en0_no_load", out_valid, 8'h00);
    en = 1'b1; in_valid = 1'b0;

    // Invalid select on the 6-channel instance
    iv6 = 1'b1; is6 = 3'd7; id6 = 3'b100;
    #1 chk("bad_sel_ready", ir6, 1'b1);
    tick();
    chk("bad_sel_err", se6, 1'b1);
    chk("bad_sel_no_valid", ov6, 6'h00);
    iv6 = 1'b0;
    tick();
    chk("bad_sel_err_once", se6, 1'b0);
    en6 = 1'b0; iv6 = 1'b1;
    #1 chk("bad_sel_en0_ready", ir6, 1'b0);
    tick();
    chk("bad_sel_en0_err", se6, 1'b0);
    en6 = 1'b1; is6 = 3'd5; id6 = 3'b011;
    tick();
    chk("ch6_valid5", ov6, 6'h20);
    chk("ch6_data5", od6[17:15], 3'b011);
    iv6 = 1'b0;

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1);
      in_sel = 3'($urandom_range(0, 7));
      in_data = 3'($urandom_range(0, 7));
      out_ready = 8'($urandom);
      tick();
    end
    en = 1'b1; in_valid = 1'b0; out_ready = 8'hFF;
    tick(); tick();
    chk("rand_drained", out_valid, 8'h00);

    // Mid-operation reset discards buffered words
    out_ready = 8'h00; in_valid = 1'b1; in_sel = 3'd1; in_data = 3'b001;
    tick();
    in_sel = 3'd3;
    tick();
    chk("mid_fill", out_valid, 8'h0A);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0; out_ready = 8'hFF;
    chk("mid_rst_valid", out_valid, 8'h00);
    chk("mid_rst_data", out_data, 24'h0);

    // Statistics: three deliveries on channel 4
    in_sel = 3'd4; in_data = 3'b111;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    stat_sel = 3'd4;
`ifdef DEMUX_STATS_EN
    #1 chk("stat_ch4", stat_cnt, 16'd3);
    stat_sel = 3'd2;
    #1 chk("stat_ch2", stat_cnt, 16'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    tick();
    stat_sel = 3'd4;
    #1 chk("stat_saturate", stat_cnt, 16'hFFFF);
`else
    #1 chk("stat_tied_zero", stat_cnt, 16'h0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
